pwm_dead_time: RTL
==================

Name: pwm_dead_time

Overview:
- Per-channel dead-band generator placed directly downstream of the APB4 PWM core.
- Consumes the raw per-channel PWM waveforms (cnt >= CRx compare outputs). Produces complementary high-side/low-side gate drive pairs.
- Inserts a programmable non-overlap interval at every transition, so both switches of a half-bridge are never on together.
- Dead time and polarity come from registers held in the owning APB wrapper.

Parameters:
- CHNL_NUM, 4, number of independent PWM channels.
- DT_WIDTH, 8, width of the dead-time count in clk_i cycles.

Ports:
- clk_i  input  1  block clock, same domain as the PWM counter
- rst_i  input  1  synchronous, active-high reset
- en_i  input  1  global enable; low forces every channel to IDLE
- dt_i  input  DT_WIDTH  dead time in clk_i cycles, shared by all channels
- pol_i  input  CHNL_NUM  per-channel output polarity; 1 = both outputs active-low
- pwm_i  input  CHNL_NUM  raw PWM waveforms from the PWM core
- pwm_p_o  output  CHNL_NUM  high-side drive
- pwm_n_o  output  CHNL_NUM  low-side drive
- busy_o  output  CHNL_NUM  channel is currently inside a dead-time interval

Behaviour:
- One clock (clk_i). Reset is synchronous and active-high (rst_i). All state updates on the rising edge of clk_i.
- Each channel has an independent FSM and a DT_WIDTH-bit down-counter.
- FSM states: IDLE, HIGH, DT_H2L, LOW, DT_L2H.
- Raw outputs decoded from registered state:
  - HIGH: p=1, n=0.
  - LOW: p=0, n=1.
  - IDLE, DT_H2L, DT_L2H: p=0, n=0.
- Final outputs: pwm_p_o[k] = raw_p XOR pol_i[k], pwm_n_o[k] = raw_n XOR pol_i[k]. pol_i is combinational; no other logic between registers and outputs.
- busy_o[k] = 1 only in DT_H2L or DT_L2H.
- Reset (rst_i=1 at an edge):
  - All FSMs go to IDLE and counters clear to 0.
  - After that edge: pwm_p_o = pwm_n_o = pol_i, busy_o = 0.
  - Reset mid-dead-time aborts the interval immediately.
- en_i=0 at an edge: every channel goes to IDLE regardless of state and counter. Takes priority over all transitions below.
- IDLE with en_i=1:
  - pwm_i=1: enter DT_L2H.
  - pwm_i=0: enter DT_H2L.
  - Enabling therefore always starts with a full dead time.
- Transitions:
  - HIGH, pwm_i=0: enter DT_H2L.
  - LOW, pwm_i=1: enter DT_L2H.
  - Otherwise HIGH and LOW hold.
- Entering a DT state:
  - Counter loads dt_i-1.
  - If dt_i==0, the DT state is skipped: HIGH->LOW or LOW->HIGH directly; IDLE goes straight to HIGH or LOW.
- In a DT state:
  - Counter==0: exit to the target state (DT_H2L->LOW, DT_L2H->HIGH).
  - Otherwise decrement.
  - Dead interval is therefore exactly dt_i cycles.
- Latency: pwm_i change sampled at edge t. Outputs go both-off after edge t. The new side turns on after edge t+dt_i (dt_i>=1), or after edge t when dt_i==0.
- Glitch / short-pulse abort (input reverts before dead time expires):
  - DT_H2L with pwm_i=1: return to HIGH next edge.
  - DT_L2H with pwm_i=0: return to LOW next edge.
  - The opposite side never turns on.
- dt_i is sampled only at DT entry. Changes during an interval take effect at the next transition.
- Maximum dead time: 2^DT_WIDTH-1 cycles. No wrap; the counter never decrements below 0.
- Invariant: raw_p & raw_n == 0 in every cycle, for all inputs.

Test Plan:
- Reset: rst_i=1 with pol_i=4'b0010 -> pwm_p_o=pwm_n_o=4'b0010, busy_o=0. Then en_i=1, dt_i=3, pwm_i[0]=1 -> ch0 busy for 3 cycles with p=n=0, then p=1, n=0.
- Square wave: pwm_i[0] period 20, duty 50%, dt_i=3 -> each edge yields exactly 3 cycles of p=n=0. p high 7 cycles, n high 7 cycles per period. No overlap ever.
- Zero dead time: dt_i=0, pwm_i[1] toggling -> outputs follow pwm_i with 1-cycle latency, busy_o[1] never asserts, p and n never both 1.
- Short pulse: dt_i=5, ch2 in HIGH, pwm_i[2] low for 2 cycles -> DT_H2L entered then aborted back to HIGH. pwm_n_o[2] stays 0 throughout.
- Mid-interval control:
  - dt_i changes 4->10 during DT -> current interval still 4 cycles, next interval 10.
  - en_i=0 during DT -> all outputs equal pol_i next cycle.
  - Re-enable -> full dead time before any side turns on.
- Polarity and invariant: pol_i=4'b1111 with random pwm_i and random dt_i in 0..15 -> outputs are the bitwise inverse of pol_i=0 runs. Assertion never sees both raw sides active together.

Source files
------------

// File: rtl/pwm_dead_time.sv
// Dead-band generator: turns raw PWM waveforms into complementary
// high-side/low-side gate drives with a programmable non-overlap gap.
module pwm_dead_time #(
  parameter int CHNL_NUM = 4,
  parameter int DT_WIDTH = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                en_i,
  input  logic [DT_WIDTH-1:0] dt_i,
  input  logic [CHNL_NUM-1:0] pol_i,
  input  logic [CHNL_NUM-1:0] pwm_i,
  output logic [CHNL_NUM-1:0] pwm_p_o,
  output logic [CHNL_NUM-1:0] pwm_n_o,
  output logic [CHNL_NUM-1:0] busy_o
);

  typedef enum logic [2:0] {
    IDLE,
    HIGH,
    DT_H2L,
    LOW,
    DT_L2H
  } state_t;

  logic [CHNL_NUM-1:0] raw_p;
  logic [CHNL_NUM-1:0] raw_n;
  logic [CHNL_NUM-1:0] busy_q;

  logic                dt_zero;
  logic [DT_WIDTH-1:0] dt_load;

  assign dt_zero = (dt_i == '0);
  assign dt_load = dt_i - DT_WIDTH'(1);

  for (genvar k = 0; k < CHNL_NUM; k++) begin : g_ch
    state_t              state_q;
    state_t              state_d;
    logic [DT_WIDTH-1:0] cnt_q;
    logic [DT_WIDTH-1:0] cnt_d;
    logic                p_q;
    logic                n_q;
    logic                b_q;

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (!en_i) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else begin
        unique case (state_q)
          IDLE: begin
            // Enabling always starts with a full dead time
            if (pwm_i[k]) state_d = dt_zero ? HIGH : DT_L2H;
            else          state_d = dt_zero ? LOW  : DT_H2L;
            cnt_d = dt_zero ? '0 : dt_load;
          end
          HIGH: begin
            if (!pwm_i[k]) begin
              state_d = dt_zero ? LOW : DT_H2L;
              cnt_d   = dt_zero ? '0 : dt_load;
            end
          end
          LOW: begin
            if (pwm_i[k]) begin
              state_d = dt_zero ? HIGH : DT_L2H;
              cnt_d   = dt_zero ? '0 : dt_load;
            end
          end
          DT_H2L: begin
            // A reverting input aborts the gap; the low side never fires
            if (pwm_i[k])         state_d = HIGH;
            else if (cnt_q == '0) state_d = LOW;
            else                  cnt_d   = cnt_q - DT_WIDTH'(1);
          end
          DT_L2H: begin
            if (!pwm_i[k])        state_d = LOW;
            else if (cnt_q == '0) state_d = HIGH;
            else                  cnt_d   = cnt_q - DT_WIDTH'(1);
          end
          default: begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        endcase
      end
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        state_q <= IDLE;
        cnt_q   <= '0;
        p_q     <= 1'b0;
        n_q     <= 1'b0;
        b_q     <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        p_q     <= (state_d == HIGH);
        n_q     <= (state_d == LOW);
        b_q     <= (state_d == DT_H2L) || (state_d == DT_L2H);
      end
    end

    assign raw_p[k]  = p_q;
    assign raw_n[k]  = n_q;
    assign busy_q[k] = b_q;
  end

  assign pwm_p_o = raw_p ^ pol_i;
  assign pwm_n_o = raw_n ^ pol_i;
  assign busy_o  = busy_q;

  a_no_overlap: assert property (
    @(posedge clk_i) (raw_p & raw_n) == '0
  );

endmodule
